// File: rtl/fpu_norm_iter_pkg.sv
// -----------------------------------------------------------------------------
// fpu_pkg
// Shared types and constants for the single-precision normalizer slice.
//   state_t   : normalizer FSM states (IDLE / SHIFT / DONE)
//   EXP_W     : biased exponent width
//   FRAC_W    : stored fraction width
//   MANT_W    : raw adder mantissa width {carry, hidden, fraction}
//   EXP_MAX   : all-ones exponent (Inf / NaN)
//   fp32_t    : packed IEEE-754 single {sign, exp, frac}
// -----------------------------------------------------------------------------
package fpu_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int MANT_W = 25;
    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

    function automatic fp32_t pack_fp32(input logic              s,
                                        input logic [EXP_W-1:0]  e,
                                        input logic [FRAC_W-1:0] f);
        fp32_t r;
        r.sign = s;
        r.exp  = e;
        r.frac = f;
        return r;
    endfunction

endpackage

// File: rtl/fpu_norm_iter_if.sv
// -----------------------------------------------------------------------------
// fpu_norm_iter_if
// Operand / result handshake bundle of the normalizer.
//   in_valid/in_ready   : operand handshake (in_sign, in_exp, in_mant)
//   out_valid/out_ready : result handshake (out_result + status flags)
// Modports:
//   master : upstream/downstream side (drives operands and out_ready)
//   slave  : the normalizer itself
// -----------------------------------------------------------------------------
interface fpu_norm_iter_if;
    import fpu_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic              in_sign;
    logic [EXP_W-1:0]  in_exp;
    logic [MANT_W-1:0] in_mant;

    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_result;
    logic              out_zero;
    logic              out_overflow;
    logic              out_underflow;

    modport master (
        output in_valid, in_sign, in_exp, in_mant, out_ready,
        input  in_ready, out_valid, out_result, out_zero, out_overflow, out_underflow
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_mant, out_ready,
        output in_ready, out_valid, out_result, out_zero, out_overflow, out_underflow
    );

endinterface

// File: rtl/fpu_norm_step.sv
// -----------------------------------------------------------------------------
// fpu_norm_step
// Combinational single normalization step (one left shift per evaluation).
// Optional macro: FPU_NORM_NIBBLE_EN -- adds a 4-bit shift when the top
// nibble below the carry is clear and the exponent can absorb it.
// Ports:
//   i_mant        : current mantissa (carry bit already resolved)
//   i_exp         : current biased exponent
//   o_next_mant   : mantissa after this step
//   o_next_exp    : exponent after this step
//   o_stop        : normalization finished (hidden bit set or exponent floor)
//   o_underflow   : finished at the exponent floor -> denormal result
// -----------------------------------------------------------------------------
module fpu_norm_step
    import fpu_pkg::*;
(
    input  logic [MANT_W-1:0] i_mant,
    input  logic [EXP_W-1:0]  i_exp,
    output logic [MANT_W-1:0] o_next_mant,
    output logic [EXP_W-1:0]  o_next_exp,
    output logic              o_stop,
    output logic              o_underflow
);

    logic w_hidden;
    logic w_exp_floor;

    assign w_hidden    = i_mant[FRAC_W];
    // At exp 1 a further shift would need exp 0 with an implied hidden bit,
    // so the value is emitted as a denormal instead.
    assign w_exp_floor = (i_exp <= EXP_W'(1));

    always_comb begin
        o_next_mant = i_mant;
        o_next_exp  = i_exp;
        o_stop      = 1'b0;
        o_underflow = 1'b0;
        if (w_hidden) begin
            o_stop = 1'b1;
        end else if (w_exp_floor) begin
            o_stop      = 1'b1;
            o_underflow = 1'b1;
            o_next_exp  = '0;
        end
`ifdef FPU_NORM_NIBBLE_EN
        // Four single steps would all be taken here anyway (no hidden bit can
        // appear in the first three and exp stays >= 2), so jump directly.
        else if ((i_mant[FRAC_W -: 4] == 4'b0000) && (i_exp > EXP_W'(4))) begin
            o_next_mant = i_mant << 4;
            o_next_exp  = i_exp - EXP_W'(4);
        end
`endif
        else begin
            o_next_mant = i_mant << 1;
            o_next_exp  = i_exp - EXP_W'(1);
        end
    end

endmodule

// File: rtl/fpu_norm_iter.sv
// -----------------------------------------------------------------------------
// fpu_norm_iter
// Iterative post-subtraction normalizer. Takes the adder's raw 25-bit mantissa
// and exponent, resolves carry-out, cancellation, overflow and pass-through
// directly, otherwise left-shifts until the hidden bit is set or the exponent
// reaches its floor, then presents a packed IEEE-754 word.
// Optional macro: FPU_NORM_NIBBLE_EN (nibble shifts in fpu_norm_step).
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : fpu_norm_iter_if.slave (operand in, result out, flags)
// -----------------------------------------------------------------------------
module fpu_norm_iter
    import fpu_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    fpu_norm_iter_if.slave bus
);

    state_t            r_state;
    logic              r_sign;
    logic [EXP_W-1:0]  r_exp;
    logic [MANT_W-1:0] r_mant;
    fp32_t             r_result;
    logic              r_zero;
    logic              r_overflow;
    logic              r_underflow;

    state_t            w_state_next;
    logic              w_sign_next;
    logic [EXP_W-1:0]  w_exp_next;
    logic [MANT_W-1:0] w_mant_next;
    fp32_t             w_result_next;
    logic              w_zero_next;
    logic              w_overflow_next;
    logic              w_underflow_next;

    logic [EXP_W-1:0]  w_carry_exp;
    logic [MANT_W-1:0] w_carry_mant;

    logic [MANT_W-1:0] w_step_mant;
    logic [EXP_W-1:0]  w_step_exp;
    logic              w_step_stop;
    logic              w_step_underflow;

    fpu_norm_step u_step (
        .i_mant      (r_mant),
        .i_exp       (r_exp),
        .o_next_mant (w_step_mant),
        .o_next_exp  (w_step_exp),
        .o_stop      (w_step_stop),
        .o_underflow (w_step_underflow)
    );

    // Carry path: only reached when in_exp != EXP_MAX, so the increment
    // cannot wrap.
    assign w_carry_exp  = bus.in_exp + EXP_W'(1);
    assign w_carry_mant = bus.in_mant >> 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_sign      <= 1'b0;
            r_exp       <= '0;
            r_mant      <= '0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_sign      <= w_sign_next;
            r_exp       <= w_exp_next;
            r_mant      <= w_mant_next;
            r_result    <= w_result_next;
            r_zero      <= w_zero_next;
            r_overflow  <= w_overflow_next;
            r_underflow <= w_underflow_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_sign_next      = r_sign;
        w_exp_next       = r_exp;
        w_mant_next      = r_mant;
        w_result_next    = r_result;
        w_zero_next      = r_zero;
        w_overflow_next  = r_overflow;
        w_underflow_next = r_underflow;

        unique case (r_state)
            IDLE: begin
                if (bus.in_valid) begin
                    w_sign_next      = bus.in_sign;
                    w_exp_next       = bus.in_exp;
                    w_mant_next      = bus.in_mant;
                    w_zero_next      = 1'b0;
                    w_overflow_next  = 1'b0;
                    w_underflow_next = 1'b0;
                    w_state_next     = DONE;
                    if (bus.in_exp == EXP_MAX) begin
                        w_result_next = pack_fp32(bus.in_sign, EXP_MAX, bus.in_mant[FRAC_W-1:0]);
                    end else if (bus.in_mant == '0) begin
                        w_result_next = '0;
                        w_zero_next   = 1'b1;
                    end else if (bus.in_mant[MANT_W-1]) begin
                        w_exp_next  = w_carry_exp;
                        w_mant_next = w_carry_mant;
                        if (w_carry_exp == EXP_MAX) begin
                            w_result_next   = pack_fp32(bus.in_sign, EXP_MAX, '0);
                            w_overflow_next = 1'b1;
                        end else begin
                            w_result_next = pack_fp32(bus.in_sign, w_carry_exp,
                                                      w_carry_mant[FRAC_W-1:0]);
                        end
                    end else if (bus.in_mant[FRAC_W] || (bus.in_exp == '0)) begin
                        w_result_next = pack_fp32(bus.in_sign, bus.in_exp, bus.in_mant[FRAC_W-1:0]);
                    end else begin
                        w_state_next = SHIFT;
                    end
                end
            end
            SHIFT: begin
                w_exp_next  = w_step_exp;
                w_mant_next = w_step_mant;
                if (w_step_stop) begin
                    w_state_next     = DONE;
                    w_underflow_next = w_step_underflow;
                    w_result_next    = pack_fp32(r_sign, w_step_exp, w_step_mant[FRAC_W-1:0]);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign bus.in_ready      = (r_state == IDLE);
    assign bus.out_valid     = (r_state == DONE);
    assign bus.out_result    = r_result;
    assign bus.out_zero      = r_zero;
    assign bus.out_overflow  = r_overflow;
    assign bus.out_underflow = r_underflow;

endmodule

// File: tb/tb_fpu_norm_iter.sv
module tb_fpu_norm_iter;

    logic clk;
    logic rst_n;

    fpu_norm_iter_if bus ();

    fpu_norm_iter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Current expectation, consumed by the monitor whenever out_valid is high.
    bit          exp_active = 1'b0;
    logic [31:0] exp_result;
    logic        exp_zero, exp_ovf, exp_unf;

    // Values captured by the most recent run_op, for literal pins.
    logic [31:0] last_result;
    logic        last_zero, last_ovf, last_unf;
    int          last_lat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model from the arithmetic definition: count the leading zeros
    // above the first set bit, limit the shifts by how far the exponent can
    // go down (it stops at 1), and report a denormal if the budget runs out.
    // lat = clock edges after the accepting edge until out_valid is seen.
    function automatic void model(input logic s, input logic [7:0] e, input logic [24:0] m,
                                  output logic [31:0] r, output logic z, output logic o,
                                  output logic u, output int lat);
        int          p, k, sh;
        logic [24:0] mm;
        logic [7:0]  eo;
        z = 0; o = 0; u = 0; lat = 0; p = 0;
        if (e == 8'hFF) begin
            r = {s, 8'hFF, m[22:0]};
        end else if (m == 25'd0) begin
            r = 32'd0;
            z = 1;
        end else if (m[24]) begin
            if (e == 8'hFE) begin
                r = {s, 8'hFF, 23'd0};
                o = 1;
            end else begin
                eo = e + 8'd1;
                r  = {s, eo, m[23:1]};
            end
        end else if (m[23] || e == 8'd0) begin
            r = {s, e, m[22:0]};
        end else begin
            for (int i = 0; i < 24; i++) if (m[i]) p = i;
            k  = 23 - p;
            sh = (k <= int'(e) - 1) ? k : int'(e) - 1;
            mm = m << sh;
`ifdef FPU_NORM_NIBBLE_EN
            lat = sh / 4 + sh % 4 + 1;
`else
            lat = sh + 1;
`endif
            if (k <= int'(e) - 1) begin
                eo = e - 8'(sh);
                r  = {s, eo, mm[22:0]};
            end else begin
                u = 1;
                r = {s, 8'd0, mm[22:0]};
            end
        end
    endfunction

    // Compare process: every cycle a result is held, it must match the model
    // and the block must refuse new operands.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            if (!exp_active) begin
                check("unexpected_valid", 32'(bus.out_valid), 32'(0));
            end else begin
                check("result", bus.out_result, exp_result);
                check("zero", 32'(bus.out_zero), 32'(exp_zero));
                check("overflow", 32'(bus.out_overflow), 32'(exp_ovf));
                check("underflow", 32'(bus.out_underflow), 32'(exp_unf));
                check("in_ready_busy", 32'(bus.in_ready), 32'(0));
            end
        end
    end

    task automatic run_op(input logic s, input logic [7:0] e, input logic [24:0] m, input int hold);
        logic [31:0] r;
        logic        z, o, u;
        int          lat, n;
        bit          got;
        model(s, e, m, r, z, o, u, lat);
        @(negedge clk);
        check("in_ready_idle", 32'(bus.in_ready), 32'(1));
        bus.in_valid = 1'b1;
        bus.in_sign  = s;
        bus.in_exp   = e;
        bus.in_mant  = m;
        exp_result   = r;
        exp_zero     = z;
        exp_ovf      = o;
        exp_unf      = u;
        @(posedge clk);
        exp_active = 1'b1;
        #1;
        // Keep offering junk while busy; it must be ignored.
        bus.in_sign = 1'($urandom);
        bus.in_exp  = 8'($urandom);
        bus.in_mant = 25'($urandom);
        n   = 0;
        got = 0;
        while (n <= 40 && !got) begin
            @(negedge clk);
            if (bus.out_valid) got = 1;
            else n++;
        end
        check("latency", 32'(n), 32'(lat));
        last_result = bus.out_result;
        last_zero   = bus.out_zero;
        last_ovf    = bus.out_overflow;
        last_unf    = bus.out_underflow;
        last_lat    = n;
        if (got) begin
            repeat (hold) @(negedge clk);
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
            @(posedge clk);
            #1 exp_active = 1'b0;
            @(negedge clk);
            bus.out_ready = 1'b0;
            check("valid_fall", 32'(bus.out_valid), 32'(0));
            check("in_ready_back", 32'(bus.in_ready), 32'(1));
        end else begin
            bus.in_valid = 1'b0;
            exp_active   = 1'b0;
        end
        $display("op s=%0d e=%h m=%h -> %h z%0d o%0d u%0d lat %0d", s, e, m,
                 last_result, last_zero, last_ovf, last_unf, last_lat);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        s;
        logic [7:0]  e;
        logic [24:0] m;
        int          cls;

        bus.in_valid  = 1'b0;
        bus.in_sign   = 1'b0;
        bus.in_exp    = 8'd0;
        bus.in_mant   = 25'd0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;
        #3;
        check("rst_in_ready", 32'(bus.in_ready), 32'(1));
        check("rst_out_valid", 32'(bus.out_valid), 32'(0));
        check("rst_result", bus.out_result, 32'd0);
        check("rst_flags", {29'd0, bus.out_zero, bus.out_overflow, bus.out_underflow}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed cases with hand-computed expectations.
        run_op(1'b0, 8'h80, 25'h0800000, 0);
        check("pin_norm", last_result, 32'h40000000);
        check("pin_norm_lat", 32'(last_lat), 32'(0));
        run_op(1'b0, 8'h7F, 25'h1800000, 0);
        check("pin_carry", last_result, 32'h40400000);
        run_op(1'b0, 8'hFE, 25'h1000000, 0);
        check("pin_ovf", last_result, 32'h7F800000);
        check("pin_ovf_flag", 32'(last_ovf), 32'(1));
        run_op(1'b0, 8'h80, 25'h0000001, 0);
        check("pin_deep", last_result, 32'h34800000);
`ifdef FPU_NORM_NIBBLE_EN
        check("pin_deep_lat", 32'(last_lat), 32'(9));
`else
        check("pin_deep_lat", 32'(last_lat), 32'(24));
`endif
        run_op(1'b0, 8'h03, 25'h0000100, 0);
        check("pin_unf", last_result, 32'h00000400);
        check("pin_unf_flag", 32'(last_unf), 32'(1));
        run_op(1'b1, 8'h90, 25'h0000000, 0);
        check("pin_zero", last_result, 32'h00000000);
        check("pin_zero_flag", 32'(last_zero), 32'(1));
        run_op(1'b1, 8'hFF, 25'h0412345, 2);
        check("pin_pass", last_result, 32'hFFC12345);

        // Backpressure: result held for 5 cycles with in_valid junk offered.
        run_op(1'b1, 8'h40, 25'h0012345, 5);

        // Reset three cycles into a 23-shift operation.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_sign  = 1'b1;
        bus.in_exp   = 8'h80;
        bus.in_mant  = 25'h0000001;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("busy_before_rst", 32'(bus.in_ready), 32'(0));
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'(1));
        check("mid_rst_valid", 32'(bus.out_valid), 32'(0));
        check("mid_rst_result", bus.out_result, 32'd0);
        check("mid_rst_flags", {29'd0, bus.out_zero, bus.out_overflow, bus.out_underflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(1'b0, 8'h85, 25'h0040000, 1);
        check("pin_after_rst", last_result, 32'h40000000);

        // Randomized operands across all decision classes.
        for (int t = 0; t < 250; t++) begin
            s   = 1'($urandom);
            e   = 8'($urandom);
            m   = 25'($urandom);
            cls = $urandom_range(0, 9);
            case (cls)
                0: e = 8'hFF;
                1: m = 25'd0;
                2: m[24] = 1'b1;
                3: begin e = 8'hFE; m[24] = 1'b1; end
                4: begin e = 8'($urandom_range(0, 6)); m[24] = 1'b0; m = m >> $urandom_range(0, 24); end
                5: begin e = 8'($urandom_range(0, 30)); m[24] = 1'b0; m = m >> $urandom_range(0, 24); end
                default: begin m[24] = 1'b0; m = m >> $urandom_range(0, 23); end
            endcase
            run_op(s, e, m, $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpu_norm_iter.md
# fpu_norm_iter

Iterative post-subtraction normalizer for the single-precision FPU datapath. It sits directly downstream of the add/sub unit and consumes its raw 25-bit mantissa difference and operand exponent. It left-shifts one bit per cycle (or one nibble per cycle, when configured) until the hidden bit is set or the exponent bottoms out. It also handles carry-out right-shift, cancellation-to-zero and overflow-to-infinity, and returns a packed IEEE-754 word over a valid/ready handshake.

## Interface
Parameters:
- none (all widths come from the shared package)

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream offers an operand.
- `in_ready`  out  1  equals (state == IDLE); reads 1 during and after reset.
- `in_sign`  in  1  result sign.
- `in_exp`  in  8  biased exponent of the larger operand.
- `in_mant`  in  25  bit 24 = carry, bit 23 = hidden, bits 22:0 = fraction.
- `out_valid`  out  1  result held; reset 0.
- `out_ready`  in  1  downstream accepts.
- `out_result`  out  32  {sign, exp[7:0], frac[22:0]}; reset 0.
- `out_zero`  out  1  exact cancellation; reset 0.
- `out_overflow`  out  1  rounded up to infinity; reset 0.
- `out_underflow`  out  1  result denormal; reset 0.

## Operation
- Three states: IDLE, SHIFT, DONE.
- **Accept** happens on `in_valid & in_ready`. Sign, exp and mant are registered and all flags are cleared. Next state is decided by the first matching rule:
  - `in_exp == 8'hFF`: go to DONE. Pass through `{sign, 8'hFF, mant[22:0]}` with no flags.
  - `mant == 0`: go to DONE. Result `32'h00000000` (sign forced 0), `out_zero = 1`.
  - `mant[24] == 1`: shift mant right by 1 (LSB truncated) and set exp += 1. If the new exp is 8'hFF, result is `{sign, 8'hFF, 23'b0}` and `out_overflow = 1`. Go to DONE.
  - `mant[23] == 1` or `in_exp == 0`: go to DONE with no change.
  - Otherwise: go to SHIFT.
- **SHIFT**, evaluated each cycle in this priority order:
  - If `mant[23]`: go to DONE.
  - Else if `exp <= 1`: set exp to 0, set `out_underflow`, leave mant unchanged, go to DONE.
  - Else: shift mant left by 1, set exp -= 1, stay in SHIFT.
- **DONE**:
  - `out_valid = 1`.
  - Result and flags stay stable until `out_ready`.
  - On `out_ready`, return to IDLE (`out_valid` falls after that edge).
- Arithmetic: exp is 8-bit unsigned. Decrement is only performed when exp ≥ 2, so it never wraps. Increment is only performed from ≤ 8'hFE.
- Reset mid-operation: asynchronously return to IDLE and clear all registers and outputs. The pending operand is dropped.

## Timing
- Let E be the accepting clock edge.
- Direct cases (pass-through, zero, carry, already normalized, exp 0): `out_valid` is high after E+0, i.e. in the cycle following acceptance.
- k left shifts needed: `out_valid` is high after edge E+k+1. Worst case is k = 23, giving E+24.
- Throughput: a new operand is accepted only in IDLE, so there is at least one idle cycle between results.
- `in_ready` is combinational from state. There is no combinational path from `in_valid` to `out_*`.

## Configuration
- Macro: `FPU_NORM_NIBBLE_EN`.
- **Defined:** in SHIFT, if `mant[23:20] == 0` and `exp > 4`, shift left by 4 and set exp -= 4 in one cycle. Otherwise use the single-bit rule. Results and flags are bit-identical to the undefined build; only latency shrinks (worst case E+9).
- **Undefined:** single-bit shifts only.

## Structure
- Package `fpu_pkg` holds:
  - the state enum (IDLE/SHIFT/DONE);
  - the constants `EXP_W = 8`, `FRAC_W = 23`, `MANT_W = 25`, `EXP_MAX = 8'hFF`;
  - the packed fp32 struct {sign, exp, frac}.
- Sub-module `fpu_norm_step`: a combinational single step that takes (mant, exp) and returns (next_mant, next_exp, stop, underflow). It includes the nibble path under the macro. The FSM registers around it.

## Test plan
- **Already normalized.** Stimulus: sign 0, exp 8'h80, mant 25'h0800000. Response: `out_result` 32'h40000000, `out_valid` after E+0, no flags.
- **Carry.** Stimulus: exp 8'h7F, mant 25'h1800000. Response: 32'h40400000. Same stimulus with exp 8'hFE and mant 25'h1000000: 32'h7F800000 with `out_overflow = 1`.
- **Deep cancellation.** Stimulus: exp 8'h80, mant 25'h0000001. Response: 32'h34800000, `out_valid` after E+24 (E+9 with `FPU_NORM_NIBBLE_EN`).
- **Underflow.** Stimulus: exp 8'h03, mant 25'h0000100. Response: 32'h00000400 with `out_underflow = 1`. Separately, sign 1, exp 8'h90, mant 0: 32'h00000000 with `out_zero = 1`.
- **Backpressure.** Hold `out_ready` low for 5 cycles. Response: `out_valid`, `out_result` and flags stay stable, `in_ready` stays 0, and `in_valid` is ignored. Then one `out_ready` pulse returns the block to IDLE and `in_ready` goes to 1.
- **Reset mid-SHIFT.** Drop `rst_n` 3 cycles into a 23-shift operation. Response: all outputs are 0 immediately, `in_ready = 1`. The next operand processes correctly.
